// File: rtl/c7bbiu_rd_arb_rr.sv
// c7bbiu_rd_arb_rr: N-port AXI read-address arbiter and read-data router.
// Grants one requester at a time in round-robin order, limits outstanding bursts per port,
// routes R beats back by ID and can silently drop all in-flight data of a cancelled port.
`timescale 1ns/1ps

module c7bbiu_rd_arb_rr #(
    parameter int unsigned NPORT    = 3,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORT-1:0]        req_val,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT*8-1:0]      req_len,
    input  logic [NPORT*3-1:0]      req_size,
    input  logic [NPORT-1:0]        req_cancel,
    output logic [NPORT-1:0]        req_ack,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ID_W-1:0]         ar_id,
    output logic [ADDR_W-1:0]       ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [ID_W-1:0]         r_id,
    input  logic [DATA_W-1:0]       r_data,
    input  logic                    r_last,
    input  logic [1:0]              r_resp,
    output logic [NPORT-1:0]        rsp_val,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_last,
    output logic                    rsp_err
);

    localparam int unsigned PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUTS);

    typedef enum logic [0:0] {StIdle, StIssue} ar_state_e;

    ar_state_e         state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  ar_port_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic [2:0]        ar_size_q;

    logic [CNT_W-1:0]  outs_q [NPORT];
    logic [CNT_W-1:0]  outs_d [NPORT];
    logic [CNT_W-1:0]  drop_q [NPORT];
    logic [CNT_W-1:0]  drop_d [NPORT];

    logic              r_ready_q;
    logic [NPORT-1:0]  rsp_val_q, rsp_val_d;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_last_q;
    logic              rsp_err_q;

    logic [NPORT-1:0]  eligible;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_ok;
    logic              ar_hs;
    logic              beat;
    logic              unused_resp;

    assign unused_resp = r_resp[0];

    // A port may compete only while it has room for another outstanding burst.
    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            eligible[p] = req_val[p] && (outs_q[p] < CntMax);
        end
    end

    // Round-robin search: first eligible port at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = (32'(rr_ptr_q) + i) % NPORT;
            if (!grant_any && eligible[idx[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    assign grant_ok = (state_q == StIdle) && grant_any && !reset;
    assign req_ack  = grant_ok ? (NPORT'(1) << grant_idx) : '0;
    assign ar_hs    = (state_q == StIssue) && ar_ready;
    assign beat     = r_valid && r_ready_q;

    // AR FSM next state; the pointer advances past the port only once its AR is accepted.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ok) state_d = StIssue;
            end
            StIssue: begin
                if (ar_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (32'(ar_port_q) == NPORT - 1) ? '0 : ar_port_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-port outstanding and drop counters.
    always_comb begin
        logic inc, dec, pend;
        inc  = 1'b0;
        dec  = 1'b0;
        pend = 1'b0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            inc  = ar_hs && (32'(ar_port_q) == p);
            pend = (state_q == StIssue) && (32'(ar_port_q) == p);
            dec  = beat && r_last && (32'(r_id) == p);

            outs_d[p] = outs_q[p];
            if (inc && !dec && outs_q[p] != CntMax) begin
                outs_d[p] = outs_q[p] + 1'b1;
            end else if (dec && !inc && outs_q[p] != '0) begin
                outs_d[p] = outs_q[p] - 1'b1;
            end

            // Cancel covers every burst in flight plus one still waiting on AR; a burst
            // finishing in this very cycle is no longer in flight and is not counted.
            drop_d[p] = drop_q[p];
            if (req_cancel[p]) begin
                drop_d[p] = outs_q[p] + CNT_W'(pend) - CNT_W'(dec && outs_q[p] != '0);
            end else if (dec && drop_q[p] != '0) begin
                drop_d[p] = drop_q[p] - 1'b1;
            end
        end
    end

    // A beat is forwarded only to a known port that expects data and is not draining.
    always_comb begin
        rsp_val_d = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (beat && (32'(r_id) == p) && outs_q[p] != '0 && drop_q[p] == '0) begin
                rsp_val_d[p] = 1'b1;
            end
        end
    end

    // AR state, round-robin pointer and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            ar_port_q <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (grant_ok) begin
                ar_port_q <= grant_idx;
                ar_addr_q <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                ar_len_q  <= req_len[grant_idx*8 +: 8];
                ar_size_q <= req_size[grant_idx*3 +: 3];
            end
        end
    end

    // Outstanding and drop counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                outs_q[p] <= '0;
                drop_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                outs_q[p] <= outs_d[p];
                drop_q[p] <= drop_d[p];
            end
        end
    end

    // R path: always ready out of reset, every beat registered onto the shared response bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_q  <= 1'b0;
            rsp_val_q  <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            r_ready_q <= 1'b1;
            rsp_val_q <= rsp_val_d;
            if (beat) begin
                rsp_data_q <= r_data;
                rsp_last_q <= r_last;
                rsp_err_q  <= r_resp[1];
            end
        end
    end

    assign ar_valid = (state_q == StIssue);
    assign ar_id    = ID_W'(ar_port_q);
    assign ar_addr  = ar_addr_q;
    assign ar_len   = ar_len_q;
    assign ar_size  = ar_size_q;
    assign ar_burst = (ar_len_q != 8'd0) ? 2'b01 : 2'b00;
    assign r_ready  = r_ready_q;
    assign rsp_val  = rsp_val_q;
    assign rsp_data = rsp_data_q;
    assign rsp_last = rsp_last_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_c7bbiu_rd_arb_rr.sv
// Scoreboard bench for c7bbiu_rd_arb_rr: random requesters, a simple AXI slave and a
// queue-based reference model of grants, outstanding bursts and cancelled bursts.
`timescale 1ns/1ps

module tb_c7bbiu_rd_arb_rr;

    localparam int NPORT    = 3;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int ID_W     = 4;
    localparam int MAX_OUTS = 4;

    logic                    clk        = 1'b0;
    logic                    reset      = 1'b1;
    logic [NPORT-1:0]        req_val    = '0;
    logic [NPORT*ADDR_W-1:0] req_addr   = '0;
    logic [NPORT*8-1:0]      req_len    = '0;
    logic [NPORT*3-1:0]      req_size   = '0;
    logic [NPORT-1:0]        req_cancel = '0;
    logic [NPORT-1:0]        req_ack;
    logic                    ar_valid;
    logic                    ar_ready   = 1'b0;
    logic [ID_W-1:0]         ar_id;
    logic [ADDR_W-1:0]       ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    r_valid    = 1'b0;
    logic                    r_ready;
    logic [ID_W-1:0]         r_id       = '0;
    logic [DATA_W-1:0]       r_data     = '0;
    logic                    r_last     = 1'b0;
    logic [1:0]              r_resp     = '0;
    logic [NPORT-1:0]        rsp_val;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_last;
    logic                    rsp_err;

    c7bbiu_rd_arb_rr #(
        .NPORT   (NPORT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W),
        .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_cancel(req_cancel),
        .req_ack   (req_ack),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_id     (ar_id),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_id      (r_id),
        .r_data    (r_data),
        .r_last    (r_last),
        .r_resp    (r_resp),
        .rsp_val   (rsp_val),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        int               id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
    } ar_t;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        bit                last;
        bit                err;
    } rsp_t;

    // Per port: one entry per accepted-but-unfinished burst, flag = data to be discarded.
    bit   plist [NPORT][$];
    ar_t  exp_ar[$];
    rsp_t exp_rsp[$];
    int   sl_id[$];
    int   sl_beats[$];
    int   ack_log[$];
    int   rr       = 0;
    bit   issuing  = 1'b0;
    int   iss_port = 0;
    int   m_exp_p;
    int   m_idx;
    ar_t  m_ar;

    // Requester-side record of what each port is currently asking for.
    logic [ADDR_W-1:0] ra [NPORT];
    logic [7:0]        rl [NPORT];
    logic [2:0]        rs [NPORT];

    bit req_en    = 1'b0;
    bit cancel_en = 1'b0;
    bit slave_en  = 1'b0;
    bit ar_rand   = 1'b0;
    int req_pct   = 0;
    logic [NPORT-1:0] ack_s;

    function automatic int model_busy();
        int n;
        n = sl_id.size() + exp_ar.size() + ((req_val != '0) ? 1 : 0);
        for (int p = 0; p < NPORT; p++) n += plist[p].size();
        return n;
    endfunction

    // Stimulus: requesters, cancels, AR ready and the R-channel slave.
    always begin
        @(negedge clk);
        ack_s = req_ack;
        @(posedge clk);
        #1;
        if (reset) begin
            req_val    = '0;
            req_cancel = '0;
            r_valid    = 1'b0;
            ar_ready   = 1'b0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (req_val[p] && ack_s[p]) req_val[p] = 1'b0;
                if (!req_val[p] && req_en && $urandom_range(99) < req_pct) begin
                    ra[p] = $urandom;
                    rl[p] = 8'($urandom_range(7));
                    rs[p] = 3'($urandom_range(7));
                    req_addr[p*ADDR_W +: ADDR_W] = ra[p];
                    req_len[p*8 +: 8]            = rl[p];
                    req_size[p*3 +: 3]           = rs[p];
                    req_val[p]                   = 1'b1;
                end
            end
            req_cancel = '0;
            if (cancel_en && $urandom_range(99) < 3) req_cancel[$urandom_range(NPORT-1)] = 1'b1;
            ar_ready = ar_rand ? ($urandom_range(99) < 60) : 1'b1;
            r_valid  = 1'b0;
            r_last   = 1'b0;
            r_id     = '0;
            r_resp   = 2'b00;
            if (slave_en && sl_id.size() > 0 && $urandom_range(99) < 70) begin
                r_valid = 1'b1;
                r_id    = ID_W'(sl_id[0]);
                r_last  = (sl_beats[0] == 1);
                r_data  = {$urandom, $urandom};
                m_idx   = $urandom_range(99);
                r_resp  = (m_idx < 10) ? 2'b10 : (m_idx < 15) ? 2'b11 : (m_idx < 20) ? 2'b01 : 2'b00;
            end else if (slave_en && $urandom_range(99) < 3) begin
                // Unsolicited beat on an ID no port owns.
                r_valid = 1'b1;
                r_id    = ID_W'($urandom_range(15, NPORT));
                r_last  = 1'($urandom_range(1));
                r_data  = {$urandom, $urandom};
            end
        end
    end

    // Model: checks grants and AR, predicts responses, tracks bursts.
    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) plist[p].delete();
            exp_ar.delete();
            exp_rsp.delete();
            issuing = 1'b0;
            rr      = 0;
        end else begin
            m_exp_p = -1;
            if (!issuing) begin
                for (int i = 0; i < NPORT; i++) begin
                    m_idx = (rr + i) % NPORT;
                    if (m_exp_p < 0 && req_val[m_idx] && plist[m_idx].size() < MAX_OUTS)
                        m_exp_p = m_idx;
                end
            end
            chk("req_ack", req_ack, (m_exp_p >= 0) ? (64'd1 << m_exp_p) : 64'd0);
            for (int p = 0; p < NPORT; p++) if (req_ack[p]) ack_log.push_back(p);
            chk("ar_valid", ar_valid, issuing);
            if (ar_valid && exp_ar.size() > 0) begin
                m_ar = exp_ar[0];
                chk("ar_id", ar_id, m_ar.id);
                chk("ar_addr", ar_addr, m_ar.addr);
                chk("ar_len", ar_len, m_ar.len);
                chk("ar_size", ar_size, m_ar.size);
                chk("ar_burst", ar_burst, (m_ar.len != 8'd0) ? 2'b01 : 2'b00);
            end

            if (r_valid && r_ready) begin
                m_idx = int'(r_id);
                if (m_idx < NPORT && plist[m_idx].size() > 0) begin
                    if (!plist[m_idx][0])
                        exp_rsp.push_back('{m_idx, r_data, r_last, r_resp[1]});
                    if (r_last) void'(plist[m_idx].pop_front());
                end
                if (sl_id.size() > 0 && int'(r_id) == sl_id[0]) begin
                    sl_beats[0] = sl_beats[0] - 1;
                    if (sl_beats[0] == 0) begin
                        void'(sl_id.pop_front());
                        void'(sl_beats.pop_front());
                    end
                end
            end

            for (int p = 0; p < NPORT; p++) begin
                if (req_cancel[p]) begin
                    for (int k = 0; k < plist[p].size(); k++) plist[p][k] = 1'b1;
                end
            end

            if (ar_valid && ar_ready) begin
                if (exp_ar.size() > 0) void'(exp_ar.pop_front());
                issuing = 1'b0;
                rr      = (iss_port + 1) % NPORT;
                sl_id.push_back(int'(ar_id));
                sl_beats.push_back(int'(ar_len) + 1);
            end

            if (m_exp_p >= 0) begin
                plist[m_exp_p].push_back(1'b0);
                exp_ar.push_back('{m_exp_p, ra[m_exp_p], rl[m_exp_p], rs[m_exp_p]});
                issuing  = 1'b1;
                iss_port = m_exp_p;
            end
        end
    end

    // Response monitor: every rsp_val pulse must match the oldest predicted beat.
    rsp_t mon_e;
    always @(negedge clk) begin
        if (!reset && rsp_val != '0) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", rsp_val, 0);
            end else begin
                mon_e = exp_rsp.pop_front();
                chk("rsp_val", rsp_val, 64'd1 << mon_e.port);
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_last", rsp_last, mon_e.last);
                chk("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    int rr_order [4] = '{0, 1, 2, 0};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ar_valid", ar_valid, 0);
        chk("reset_req_ack", req_ack, 0);
        chk("reset_rsp_val", rsp_val, 0);
        chk("reset_rsp_last", rsp_last, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_r_ready", r_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("r_ready_after_reset", r_ready, 1);

        // All ports request continuously, no R data: round robin until every port saturates.
        req_en  = 1'b1;
        req_pct = 100;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (ack_log.size() > i) ? ack_log[i] : -1, rr_order[i]);
        chk("saturated_grants", ack_log.size(), NPORT * MAX_OUTS);

        // Release data; then full random traffic with stalls and cancels.
        slave_en = 1'b1;
        repeat (300) @(negedge clk);
        req_pct   = 30;
        ar_rand   = 1'b1;
        cancel_en = 1'b1;
        repeat (3000) @(negedge clk);

        req_en    = 1'b0;
        cancel_en = 1'b0;
        for (int w = 0; w < 5000 && model_busy() != 0; w++) @(negedge clk);
        chk("drain_done", model_busy(), 0);
        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", exp_rsp.size(), 0);

        // Reset in the middle of traffic; leftover slave beats must be discarded.
        req_en  = 1'b1;
        req_pct = 100;
        ar_rand = 1'b0;
        repeat (30) @(negedge clk);
        req_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midreset_ar_valid", ar_valid, 0);
        chk("midreset_req_ack", req_ack, 0);
        chk("midreset_rsp_val", rsp_val, 0);
        chk("midreset_rsp_last", rsp_last, 0);
        chk("midreset_rsp_err", rsp_err, 0);
        chk("midreset_r_ready", r_ready, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_reset_rsp_queue", exp_rsp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
